csi_rx_ctrl: RTL and testbench

Sequencing controller for the CSI receive packet path. It owns the packet handler's reset and input-valid gating, and waits out an HS settle window before arming capture. It supervises the handler's frame_active/frame_valid outputs to count words, lines and frames, flag line-length errors, and recover from stalled frames by re-resetting the handler.

---
 rtl/csi_rx_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_csi_rx_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csi_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : csi_rx_ctrl
// Description : Sequencing controller for the CSI receive packet path.
//               Holds the packet handler in reset until the HS lanes have
//               settled. It gates the aligner valid into the handler and
//               watches frame_active/frame_valid. From these it counts words,
//               lines and frames, and flags line-length errors. A stalled
//               frame is recovered by re-resetting the handler.
// Ports       : rxbyteclkhs/reset_n   - byte clock, sync active-low reset
//               enable, hs_active     - arm request, HS receive indication
//               in_valid_raw          - aligner valid before gating
//               frame_active/valid    - status from the packet handler
//               cfg_settle/line_words/timeout - runtime configuration
//               err_clear             - clears the sticky error flags
//               ph_reset, in_valid_gated - handler reset and gated valid
//               busy, line_count, frame_count, frame_done - status
//               err_line_len, err_timeout - sticky error flags
// Revision    : 1.0 - initial release
// ============================================================================
module csi_rx_ctrl #(
    parameter int CNT_WIDTH       = 16,
    parameter int FRAME_CNT_WIDTH = 16,
    parameter int SETTLE_WIDTH    = 8,
    parameter int TIMEOUT_WIDTH   = 16,
    parameter int RECOVER_CYCLES  = 4
) (
    input  logic                       rxbyteclkhs,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic                       hs_active,
    input  logic                       in_valid_raw,
    input  logic                       frame_active,
    input  logic                       frame_valid,
    input  logic [SETTLE_WIDTH-1:0]    cfg_settle,
    input  logic [CNT_WIDTH-1:0]       cfg_line_words,
    input  logic [TIMEOUT_WIDTH-1:0]   cfg_timeout,
    input  logic                       err_clear,
    output logic                       ph_reset,
    output logic                       in_valid_gated,
    output logic                       busy,
    output logic [CNT_WIDTH-1:0]       line_count,
    output logic [FRAME_CNT_WIDTH-1:0] frame_count,
    output logic                       frame_done,
    output logic                       err_line_len,
    output logic                       err_timeout
);

    localparam int REC_WIDTH = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
    localparam logic [REC_WIDTH-1:0] REC_LOAD = REC_WIDTH'(RECOVER_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_ARMED   = 3'd2,
        ST_FRAME   = 3'd3,
        ST_RECOVER = 3'd4
    } state_t;

    state_t                     state_q, state_d;
    logic [SETTLE_WIDTH-1:0]    settle_q, settle_d;
    logic [REC_WIDTH-1:0]       rec_q, rec_d;
    logic [CNT_WIDTH-1:0]       word_q, word_d;
    logic [CNT_WIDTH-1:0]       line_q, line_d;
    logic [TIMEOUT_WIDTH-1:0]   idle_q, idle_d;
    logic [FRAME_CNT_WIDTH-1:0] fcnt_q, fcnt_d;
    logic                       done_q, done_d;
    logic                       err_len_q, err_len_d;
    logic                       err_to_q, err_to_d;
    logic                       fv_prev_q, fv_prev_d;
    logic                       fa_prev_q, fa_prev_d;

    logic fv_fall;
    logic fa_fall;
    logic lanes_ok;

    assign lanes_ok = enable & hs_active;
    // fv_prev is forced low outside FRAME so a line only counts if it rose in FRAME
    assign fv_fall  = fv_prev_q & ~frame_valid;
    assign fa_fall  = fa_prev_q & ~frame_active;

    assign ph_reset       = (state_q == ST_IDLE) || (state_q == ST_SETTLE) ||
                            (state_q == ST_RECOVER);
    assign busy           = (state_q != ST_IDLE);
    assign in_valid_gated = in_valid_raw & hs_active &
                            ((state_q == ST_ARMED) || (state_q == ST_FRAME));
    assign line_count     = line_q;
    assign frame_count    = fcnt_q;
    assign frame_done     = done_q;
    assign err_line_len   = err_len_q;
    assign err_timeout    = err_to_q;

    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        rec_d     = rec_q;
        word_d    = word_q;
        line_d    = line_q;
        idle_d    = '0;
        fcnt_d    = fcnt_q;
        done_d    = 1'b0;
        err_len_d = err_clear ? 1'b0 : err_len_q;
        err_to_d  = err_clear ? 1'b0 : err_to_q;
        fv_prev_d = frame_valid & (state_q == ST_FRAME);
        fa_prev_d = frame_active;

        case (state_q)
            ST_IDLE: begin
                if (lanes_ok) begin
                    state_d  = ST_SETTLE;
                    settle_d = cfg_settle;
                end
            end
            ST_SETTLE: begin
                if (!lanes_ok) begin
                    state_d = ST_IDLE;
                end else if (settle_q == '0) begin
                    state_d = ST_ARMED;
                end else begin
                    settle_d = settle_q - SETTLE_WIDTH'(1);
                end
            end
            ST_ARMED: begin
                if (!lanes_ok) begin
                    state_d = ST_IDLE;
                end else if (frame_active) begin
                    state_d = ST_FRAME;
                    line_d  = '0;
                    word_d  = '0;
                end
            end
            ST_FRAME: begin
                if (frame_valid && (word_q != '1)) begin
                    word_d = word_q + CNT_WIDTH'(1);
                end
                // Line end is processed before frame end so frame_done sees the final line
                if (fv_fall) begin
                    if (line_q != '1) begin
                        line_d = line_q + CNT_WIDTH'(1);
                    end
                    if (word_q != cfg_line_words) begin
                        err_len_d = 1'b1;
                    end
                    word_d = '0;
                end
                if (frame_valid || in_valid_gated) begin
                    idle_d = '0;
                end else if (idle_q != '1) begin
                    idle_d = idle_q + TIMEOUT_WIDTH'(1);
                end else begin
                    idle_d = idle_q;
                end
                // Frame end has priority over a coincident stall timeout
                if (fa_fall) begin
                    done_d  = 1'b1;
                    fcnt_d  = fcnt_q + FRAME_CNT_WIDTH'(1);
                    state_d = lanes_ok ? ST_ARMED : ST_IDLE;
                end else if ((cfg_timeout != '0) && (idle_d >= cfg_timeout)) begin
                    err_to_d = 1'b1;
                    state_d  = ST_RECOVER;
                    rec_d    = REC_LOAD;
                end
            end
            ST_RECOVER: begin
                if (rec_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    rec_d = rec_q - REC_WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge rxbyteclkhs) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            settle_q  <= '0;
            rec_q     <= '0;
            word_q    <= '0;
            line_q    <= '0;
            idle_q    <= '0;
            fcnt_q    <= '0;
            done_q    <= 1'b0;
            err_len_q <= 1'b0;
            err_to_q  <= 1'b0;
            fv_prev_q <= 1'b0;
            fa_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            rec_q     <= rec_d;
            word_q    <= word_d;
            line_q    <= line_d;
            idle_q    <= idle_d;
            fcnt_q    <= fcnt_d;
            done_q    <= done_d;
            err_len_q <= err_len_d;
            err_to_q  <= err_to_d;
            fv_prev_q <= fv_prev_d;
            fa_prev_q <= fa_prev_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_csi_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_csi_rx_ctrl
// Description : Self-checking bench for csi_rx_ctrl. Frame stimulus pushes
//               the expected end-of-frame status into a queue. A monitor
//               pops and compares it on every frame_done pulse. Directed
//               sequences cover settle timing, stall recovery and aborts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csi_rx_ctrl;

    localparam int CW = 16;
    localparam int FW = 16;
    localparam int SW = 8;
    localparam int TW = 16;
    localparam int RC = 4;

    logic          clk = 1'b0;
    logic          reset_n, enable, hs_active, in_valid_raw;
    logic          frame_active, frame_valid, err_clear;
    logic [SW-1:0] cfg_settle;
    logic [CW-1:0] cfg_line_words;
    logic [TW-1:0] cfg_timeout;
    logic          ph_reset, in_valid_gated, busy, frame_done;
    logic          err_line_len, err_timeout;
    logic [CW-1:0] line_count;
    logic [FW-1:0] frame_count;

    always #5 clk = ~clk;

    csi_rx_ctrl #(
        .CNT_WIDTH      (CW),
        .FRAME_CNT_WIDTH(FW),
        .SETTLE_WIDTH   (SW),
        .TIMEOUT_WIDTH  (TW),
        .RECOVER_CYCLES (RC)
    ) dut (
        .rxbyteclkhs   (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .hs_active     (hs_active),
        .in_valid_raw  (in_valid_raw),
        .frame_active  (frame_active),
        .frame_valid   (frame_valid),
        .cfg_settle    (cfg_settle),
        .cfg_line_words(cfg_line_words),
        .cfg_timeout   (cfg_timeout),
        .err_clear     (err_clear),
        .ph_reset      (ph_reset),
        .in_valid_gated(in_valid_gated),
        .busy          (busy),
        .line_count    (line_count),
        .frame_count   (frame_count),
        .frame_done    (frame_done),
        .err_line_len  (err_line_len),
        .err_timeout   (err_timeout)
    );

    typedef struct {
        int lines;
        int fcount;
        bit err;
    } exp_t;

    exp_t exp_q[$];
    int   line_words[$];
    int   checks   = 0;
    int   failures = 0;
    int   model_fc = 0;
    bit   model_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every frame_done must match the oldest expectation
    always @(negedge clk) begin
        if (frame_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL frame_done_unexpected: got pulse expected none");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("done_line_count", line_count, e.lines);
                chk("done_frame_count", frame_count, e.fcount);
                chk("done_err_line_len", err_line_len, e.err);
            end
        end
    end

    // Counts cycles with ph_reset high from IDLE until ARMED, bounded
    task automatic arm_count(output int n);
        n = 0;
        while (ph_reset && n < 100) begin
            n++;
            tick();
        end
    endtask

    // Plays one frame using line_words; model derives the expected status
    task automatic do_frame(input bit coincident, input bit drop_en);
        int n;
        n = line_words.size();
        frame_active = 1'b1;
        frame_valid  = 1'b0;
        in_valid_raw = 1'b1;
        tick();
        repeat ($urandom_range(0, 2)) tick();
        for (int l = 0; l < n; l++) begin
            int w;
            bit last_co;
            w = line_words[l];
            last_co = (l == n - 1) && coincident;
            if (w != int'(cfg_line_words)) model_err = 1'b1;
            frame_valid = 1'b1;
            repeat (w) begin
                in_valid_raw = 1'($urandom);
                tick();
            end
            frame_valid = 1'b0;
            if (last_co) begin
                model_fc++;
                exp_q.push_back('{n, model_fc, model_err});
                frame_active = 1'b0;
            end
            tick();
            chk("err_line_len_after_line", err_line_len, model_err);
            if (l == 0 && drop_en) enable = 1'b0;
            if (!last_co) repeat ($urandom_range(0, 2)) tick();
        end
        if (!coincident) begin
            model_fc++;
            exp_q.push_back('{n, model_fc, model_err});
            frame_active = 1'b0;
            tick();
        end
        tick();
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n        = 1'b0;
        enable         = 1'b1;
        hs_active      = 1'b1;
        in_valid_raw   = 1'b1;
        frame_active   = 1'b0;
        frame_valid    = 1'b0;
        err_clear      = 1'b0;
        cfg_settle     = 8'd5;
        cfg_line_words = 16'd8;
        cfg_timeout    = 16'd20;
        repeat (3) tick();

        // Reset state
        chk("rst_ph_reset", ph_reset, 1);
        chk("rst_busy", busy, 0);
        chk("rst_gated", in_valid_gated, 0);
        chk("rst_line_count", line_count, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_err_line_len", err_line_len, 0);
        chk("rst_err_timeout", err_timeout, 0);

        // Settle window: one IDLE cycle plus cfg_settle+1 SETTLE cycles
        reset_n = 1'b1;
        arm_count(n);
        chk("settle_ph_reset_cycles", n, 1 + 5 + 1);
        chk("armed_busy", busy, 1);
        for (int i = 0; i < 6; i++) begin
            in_valid_raw = 1'($urandom);
            #1;
            chk("gated_in_armed", in_valid_gated, in_valid_raw);
            tick();
        end

        // Good frame
        line_words = '{8, 8, 8};
        do_frame(1'b0, 1'b0);
        chk("good_line_count", line_count, 3);
        chk("good_frame_count", frame_count, 1);
        chk("good_err", err_line_len, 0);

        // Short middle line, sticky until cleared
        line_words = '{8, 7, 8};
        do_frame(1'b0, 1'b0);
        chk("short_err_sticky", err_line_len, 1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        model_err = 1'b0;
        chk("short_err_cleared", err_line_len, 0);

        // Randomized frames
        for (int f = 0; f < 8; f++) begin
            line_words.delete();
            repeat ($urandom_range(1, 4)) begin
                if ($urandom_range(0, 3) == 0) line_words.push_back(7 + 2 * int'($urandom_range(0, 1)));
                else line_words.push_back(8);
            end
            do_frame(1'($urandom), 1'b0);
            if ($urandom_range(0, 1) == 1) begin
                err_clear = 1'b1;
                tick();
                err_clear = 1'b0;
                model_err = 1'b0;
                chk("rand_err_cleared", err_line_len, 0);
            end
        end

        // Coincident line/frame end with enable dropped mid-frame
        line_words = '{8, 8};
        do_frame(1'b1, 1'b1);
        chk("coinc_line_count", line_count, 2);
        chk("coinc_idle_after", busy, 0);

        // Zero settle gives a single SETTLE cycle
        cfg_settle = 8'd0;
        enable = 1'b1;
        arm_count(n);
        chk("settle0_ph_reset_cycles", n, 1 + 0 + 1);

        // Stall timeout and recovery
        cfg_timeout  = 16'd10;
        in_valid_raw = 1'b0;
        frame_valid  = 1'b0;
        frame_active = 1'b1;
        tick();
        repeat (9) tick();
        chk("stall_no_timeout_yet", err_timeout, 0);
        chk("stall_still_busy", busy, 1);
        tick();
        chk("stall_err_timeout", err_timeout, 1);
        chk("stall_ph_reset", ph_reset, 1);
        frame_active = 1'b0;
        cfg_settle   = 8'd20;
        n = 0;
        while (busy && n < 20) begin
            n++;
            tick();
        end
        chk("recover_cycles", n, RC);
        chk("stall_frame_count", frame_count, model_fc);

        // Abort during SETTLE
        tick();
        tick();
        chk("settle_busy", busy, 1);
        hs_active = 1'b0;
        tick();
        chk("abort_idle", busy, 0);
        chk("abort_ph_reset", ph_reset, 1);
        chk("timeout_sticky", err_timeout, 1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("timeout_cleared", err_timeout, 0);

        // Reset in the middle of a frame
        hs_active   = 1'b1;
        cfg_settle  = 8'd2;
        cfg_timeout = 16'd20;
        arm_count(n);
        chk("rearm_ph_reset_cycles", n, 1 + 2 + 1);
        in_valid_raw = 1'b1;
        frame_active = 1'b1;
        tick();
        frame_valid = 1'b1;
        repeat (3) tick();
        frame_valid = 1'b0;
        tick();
        chk("partial_err_set", err_line_len, 1);
        frame_valid = 1'b1;
        tick();
        reset_n = 1'b0;
        tick();
        chk("midrst_ph_reset", ph_reset, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_line_count", line_count, 0);
        chk("midrst_frame_count", frame_count, 0);
        chk("midrst_frame_done", frame_done, 0);
        chk("midrst_err_line_len", err_line_len, 0);
        chk("midrst_err_timeout", err_timeout, 0);
        frame_valid  = 1'b0;
        frame_active = 1'b0;
        reset_n      = 1'b1;
        repeat (3) tick();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
